// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage.
// Holds the EX/MEM slot, runs a single-outstanding load/store unit against a
// req/gnt/rvalid data-memory port, and drives the MEM/WB register together
// with the forwarding values used by the execute stage.
module mem_stage #(
  parameter int Size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // execute-stage slot
  input  logic            ValidE,
  input  logic [Size-1:0] ALUResultE,
  input  logic [Size-1:0] WriteDataE,
  input  logic [Size-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemReadE,
  input  logic            MemWriteE,
  input  logic [2:0]      Funct3E,
  input  logic [1:0]      ResultSrcE,
  // hazard / forwarding
  output logic            StallM,
  output logic [Size-1:0] ALUResultM,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  // data-memory port
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [Size-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [Size-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [Size-1:0] dmem_rdata,
  // writeback
  output logic [Size-1:0] ResultW,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic            MisalignM
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_t;

  // Byte enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables pick the lane.
  function automatic logic [Size-1:0] store_data(input logic [2:0] f3, input logic [Size-1:0] d);
    logic [Size-1:0] w;
    case (f3)
      3'b000:  w = {(Size/8){d[7:0]}};
      3'b001:  w = {(Size/16){d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Extract and extend the addressed byte/half of a returned load word.
  function automatic logic [Size-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [Size-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [Size-1:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{(Size-8){b[7]}}, b};
      3'b001:  r = {{(Size-16){h[15]}}, h};
      3'b100:  r = {{(Size-8){1'b0}}, b};
      3'b101:  r = {{(Size-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // True when a memory op cannot be issued: read+write together, a width code
  // that does not exist for this direction, or an address not aligned to it.
  function automatic logic bad_access(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    if (rd && wr) begin
      bad = 1'b1;
    end else begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = off[0];
        3'b010:  bad = (off != 2'b00);
        3'b100:  bad = wr;
        3'b101:  bad = wr | off[0];
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // M slot
  logic            valid_m_r;
  logic [Size-1:0] alu_m_r;
  logic [Size-1:0] wdata_m_r;
  logic [Size-1:0] pc4_m_r;
  logic [4:0]      rd_m_r;
  logic            regwrite_m_r;
  logic            memread_m_r;
  logic            memwrite_m_r;
  logic [2:0]      funct3_m_r;
  logic [1:0]      resultsrc_m_r;

  // W slot
  logic [Size-1:0] result_w_r;
  logic [4:0]      rd_w_r;
  logic            regwrite_w_r;
  logic            misalign_r;

  state_t          state_r;
  state_t          state_next_s;

  logic            mem_op_s;
  logic            illegal_s;
  logic            legal_s;
  logic            req_s;
  logic            retire_s;
  logic            stall_s;
  logic [Size-1:0] wb_result_s;

  assign mem_op_s  = valid_m_r & (memread_m_r | memwrite_m_r);
  assign illegal_s = mem_op_s & bad_access(memread_m_r, memwrite_m_r, funct3_m_r, alu_m_r[1:0]);
  assign legal_s   = mem_op_s & ~illegal_s;

  // Next-state and handshake decode; an issuable op in IDLE requests at once.
  always_comb begin
    state_next_s = IDLE;
    req_s        = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      IDLE, REQ: begin
        if (legal_s) begin
          req_s = 1'b1;
          if (dmem_gnt) begin
            if (memwrite_m_r) begin
              retire_s     = 1'b1;
              state_next_s = IDLE;
            end else begin
              state_next_s = WAIT;
            end
          end else begin
            state_next_s = REQ;
          end
        end else begin
          // non-memory op, bubble, or illegal access leaves in one cycle
          retire_s     = 1'b1;
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          retire_s     = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
        retire_s     = 1'b0;
      end
    endcase
  end

  assign stall_s = mem_op_s & ~retire_s;

  // Writeback value selection for the instruction retiring this cycle.
  always_comb begin
    wb_result_s = alu_m_r;
    case (resultsrc_m_r)
      2'b01:   wb_result_s = load_extend(funct3_m_r, alu_m_r[1:0], dmem_rdata);
      2'b10:   wb_result_s = pc4_m_r;
      default: wb_result_s = alu_m_r;
    endcase
  end

  // Load/store FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // EX/MEM register: holds while stalled, control masked for bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m_r     <= 1'b0;
      alu_m_r       <= '0;
      wdata_m_r     <= '0;
      pc4_m_r       <= '0;
      rd_m_r        <= 5'd0;
      regwrite_m_r  <= 1'b0;
      memread_m_r   <= 1'b0;
      memwrite_m_r  <= 1'b0;
      funct3_m_r    <= 3'd0;
      resultsrc_m_r <= 2'd0;
    end else if (!stall_s) begin
      valid_m_r     <= ValidE;
      alu_m_r       <= ALUResultE;
      wdata_m_r     <= WriteDataE;
      pc4_m_r       <= PCPlus4E;
      rd_m_r        <= RdE;
      regwrite_m_r  <= ValidE & RegWriteE;
      memread_m_r   <= ValidE & MemReadE;
      memwrite_m_r  <= ValidE & MemWriteE;
      funct3_m_r    <= Funct3E;
      resultsrc_m_r <= ResultSrcE;
    end else begin
      valid_m_r     <= valid_m_r;
    end
  end

  // MEM/WB register: loads on retire, otherwise inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_w_r   <= '0;
      rd_w_r       <= 5'd0;
      regwrite_w_r <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      misalign_r <= illegal_s;
      if (retire_s) begin
        result_w_r   <= wb_result_s;
        rd_w_r       <= rd_m_r;
        regwrite_w_r <= valid_m_r & regwrite_m_r & ~illegal_s;
      end else begin
        regwrite_w_r <= 1'b0;
      end
    end
  end

  assign StallM     = stall_s;
  assign ALUResultM = alu_m_r;
  assign RdM        = rd_m_r;
  assign RegWriteM  = valid_m_r & regwrite_m_r;

  // Request fields come straight from the M slot, which is frozen while stalled.
  assign dmem_req   = req_s;
  assign dmem_we    = req_s & memwrite_m_r;
  assign dmem_addr  = {alu_m_r[Size-1:2], 2'b00};
  assign dmem_be    = memwrite_m_r ? store_be(funct3_m_r, alu_m_r[1:0]) : 4'b1111;
  assign dmem_wdata = store_data(funct3_m_r, wdata_m_r);

  assign ResultW    = result_w_r;
  assign RdW        = rd_w_r;
  assign RegWriteW  = regwrite_w_r;
  assign MisalignM  = misalign_r;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a reactive memory model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ValidE = 1'b0;
  logic [31:0] ALUResultE = 32'd0, WriteDataE = 32'd0, PCPlus4E = 32'd0;
  logic [4:0]  RdE = 5'd0;
  logic        RegWriteE = 1'b0, MemReadE = 1'b0, MemWriteE = 1'b0;
  logic [2:0]  Funct3E = 3'd0;
  logic [1:0]  ResultSrcE = 2'd0;
  logic        StallM, RegWriteM, dmem_req, dmem_we, RegWriteW, MisalignM;
  logic [31:0] ALUResultM, dmem_addr, dmem_wdata, ResultW;
  logic [4:0]  RdM, RdW;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;

  // memory model configuration
  int gnt_wait = 0;      // <0 random grant, else grant after this many req cycles
  int rv_lo = 1, rv_hi = 1;
  bit spurious = 1'b0;
  int pending = 0;
  int req_age = 0;
  logic [31:0] pend_addr = 32'd0;

  typedef struct {
    logic valid; logic [31:0] alu, wd, pc4; logic [4:0] rd;
    logic regw, mrd, mwr; logic [2:0] f3; logic [1:0] rsrc;
  } ins_t;
  typedef struct { logic mis; logic [4:0] rd; logic [31:0] res; } wb_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } mreq_t;

  wb_t   wb_q[$];
  mreq_t mem_q[$];

  mem_stage #(.Size(32)) dut (
    .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE), .Funct3E(Funct3E), .ResultSrcE(ResultSrcE),
    .StallM(StallM), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // contents of the data memory, by word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h80AA_BBCC;
      32'h0000_0040: return 32'hDEAD_BEEF;
      32'h0000_0044: return 32'h8765_4321;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
  endfunction

  function automatic bit model_illegal(input ins_t t);
    if (t.mrd && t.mwr) return 1'b1;
    if (t.mrd && !(t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (t.mwr && !(t.f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    return (int'(t.alu[1:0]) % nbytes(t.f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input ins_t t);
    logic [63:0] w, v, lim;
    int nb, off;
    nb  = nbytes(t.f3);
    off = int'(t.alu[1:0]);
    w   = {32'd0, mem_word(t.alu & 32'hFFFF_FFFC)};
    lim = 64'd1 << (8 * nb);
    v   = (w >> (8 * off)) & (lim - 64'd1);
    if (nb < 4 && !t.f3[2] && v[8*nb-1]) v = v - lim;
    return v[31:0];
  endfunction

  // expected effects of an instruction accepted into the M slot
  task automatic record(input ins_t t);
    mreq_t m;
    int nb;
    if (t.valid) begin
      if ((t.mrd || t.mwr) && model_illegal(t)) begin
        wb_q.push_back('{1'b1, t.rd, 32'd0});
      end else if (t.mrd || t.mwr) begin
        nb      = nbytes(t.f3);
        m.addr  = t.alu & 32'hFFFF_FFFC;
        m.we    = t.mwr;
        m.be    = t.mwr ? 4'(((1 << nb) - 1) << t.alu[1:0]) : 4'b1111;
        m.wdata = (nb == 1) ? {24'd0, t.wd[7:0]} * 32'h0101_0101 :
                  (nb == 2) ? {16'd0, t.wd[15:0]} * 32'h0001_0001 : t.wd;
        mem_q.push_back(m);
        if (t.mrd && t.regw) wb_q.push_back('{1'b0, t.rd, model_load(t)});
      end else if (t.regw) begin
        wb_q.push_back('{1'b0, t.rd, (t.rsrc == 2'b10) ? t.pc4 : t.alu});
      end
    end
  endtask

  task automatic drive(input ins_t t);
    ValidE = t.valid; ALUResultE = t.alu; WriteDataE = t.wd; PCPlus4E = t.pc4;
    RdE = t.rd; RegWriteE = t.regw; MemReadE = t.mrd; MemWriteE = t.mwr;
    Funct3E = t.f3; ResultSrcE = t.rsrc;
  endtask

  // present an instruction and hold it until the stage accepts it
  task automatic issue(input ins_t t);
    int guard;
    @(negedge clk);
    drive(t);
    guard = 0;
    #4;
    while (StallM && guard < 200) begin
      @(negedge clk);
      #4;
      guard++;
    end
    if (StallM) fail_now("issue_timeout");
    else record(t);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ValidE = 1'b0;
    end
  endtask

  function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                              input logic regw, input logic mrd, input logic mwr,
                              input logic [2:0] f3, input logic [1:0] rsrc);
    ins_t t;
    t.valid = 1'b1; t.alu = alu; t.wd = wd; t.pc4 = 32'h0000_8004; t.rd = rd;
    t.regw = regw; t.mrd = mrd; t.mwr = mwr; t.f3 = f3; t.rsrc = rsrc;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int k, nb;
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    k = $urandom_range(0, 9);
    t = mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 2'b00);
    t.pc4   = $urandom;
    t.valid = ($urandom_range(0, 9) != 0);
    if (k <= 2) begin
      t.regw = 1'($urandom_range(0, 1));
      t.rsrc = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
    end else if (k <= 5) begin
      t.mrd = 1'b1; t.regw = 1'b1; t.rsrc = 2'b01;
      if ($urandom_range(0, 7) != 0) t.f3 = ld_f3[$urandom_range(0, 4)];
    end else if (k <= 8) begin
      t.mwr = 1'b1;
      if ($urandom_range(0, 7) != 0) t.f3 = 3'($urandom_range(0, 2));
    end else begin
      t.mrd = 1'b1; t.mwr = 1'b1; t.regw = 1'b1;
    end
    nb = nbytes(t.f3);
    if ($urandom_range(0, 3) != 0) t.alu = t.alu & ~32'(nb - 1);
    return t;
  endfunction

  // memory responder: grants, returns load data, checks each request
  initial forever begin
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = mem_word(pend_addr);
      end
    end
    if (!dmem_rvalid) begin
      dmem_rdata = $urandom;
      if (dmem_req) dmem_gnt = (gnt_wait >= 0) ? (req_age >= gnt_wait) : ($urandom_range(0, 1) == 1);
      if (spurious && pending == 0 && !dmem_gnt && $urandom_range(0, 7) == 0) dmem_rvalid = 1'b1;
    end
    #4;
    if (rst_n && dmem_req) begin
      if (pending > 0) fail_now("req_during_wait");
      if (mem_q.size() == 0) begin
        fail_now("unexpected_req");
      end else begin
        check("req_addr", dmem_addr, mem_q[0].addr);
        check("req_we", 32'(dmem_we), 32'(mem_q[0].we));
        check("req_be", 32'(dmem_be), 32'(mem_q[0].be));
        if (mem_q[0].we) check("req_wdata", dmem_wdata, mem_q[0].wdata);
        if (dmem_gnt) begin
          if (!mem_q[0].we) begin
            pending   = $urandom_range(rv_lo, rv_hi);
            pend_addr = dmem_addr;
          end
          void'(mem_q.pop_front());
        end
      end
      req_age = dmem_gnt ? 0 : req_age + 1;
    end
  end

  // stall cycle counter
  initial forever begin
    @(negedge clk);
    #4;
    if (rst_n && StallM) stall_cnt++;
  end

  // writeback monitor
  initial forever begin
    wb_t e;
    @(posedge clk);
    #1;
    if (rst_n && (RegWriteW || MisalignM)) begin
      if (wb_q.size() == 0) begin
        fail_now("unexpected_wb");
      end else begin
        e = wb_q.pop_front();
        check("wb_misalign", 32'(MisalignM), 32'(e.mis));
        check("wb_regwrite", 32'(RegWriteW), 32'(!e.mis));
        if (!e.mis) begin
          check("wb_rd", 32'(RdW), 32'(e.rd));
          check("wb_result", ResultW, e.res);
        end
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ALUResultM", ALUResultM, 32'd0);
    check("rst_RdM", 32'(RdM), 32'd0);
    check("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_StallM", 32'(StallM), 32'd0);
    check("rst_MisalignM", 32'(MisalignM), 32'd0);
    check("rst_ResultW", ResultW, 32'd0);
    check("rst_RdW", 32'(RdW), 32'd0);
    check("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    rst_n = 1'b1;

    // ALU op: one cycle in M, no stall
    stall_cnt = 0;
    issue(mk(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00));
    @(posedge clk);
    #1;
    check("add_ALUResultM", ALUResultM, 32'h0000_1234);
    check("add_RdM", 32'(RdM), 32'd5);
    check("add_RegWriteM", 32'(RegWriteM), 32'd1);
    idle(4);
    check("add_stall", 32'(stall_cnt), 32'd0);

    // LB at 0x103, immediate grant, data next cycle
    stall_cnt = 0;
    issue(mk(32'h0000_0103, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000, 2'b01));
    idle(6);
    check("lb_stall", 32'(stall_cnt), 32'd1);

    // SH at 0x202 with grant held back 3 cycles; a following op must wait
    stall_cnt = 0;
    gnt_wait  = 3;
    issue(mk(32'h0000_0202, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00));
    issue(mk(32'h0000_0777, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00));
    idle(8);
    check("sh_stall", 32'(stall_cnt), 32'd3);
    gnt_wait = 0;

    // misaligned LW: no request, no stall
    stall_cnt = 0;
    issue(mk(32'h0000_1001, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01));
    idle(4);
    check("lw_mis_stall", 32'(stall_cnt), 32'd0);

    // back-to-back LW then LHU
    stall_cnt = 0;
    issue(mk(32'h0000_0040, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01));
    issue(mk(32'h0000_0046, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b101, 2'b01));
    idle(8);
    check("b2b_stall", 32'(stall_cnt), 32'd2);

    // randomized traffic with random grant/data latency and stray rvalid
    gnt_wait = -1; rv_lo = 1; rv_hi = 3; spurious = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(rand_ins());
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    idle(20);

    // reset while a load waits for data; the late rvalid must be ignored
    gnt_wait = 0; rv_lo = 6; rv_hi = 6; spurious = 1'b0;
    issue(mk(32'h0000_0040, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01));
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw_dmem_req", 32'(dmem_req), 32'd0);
    check("rstw_StallM", 32'(StallM), 32'd0);
    check("rstw_RegWriteW", 32'(RegWriteW), 32'd0);
    wb_q.delete();
    mem_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("rstw_after_RegWriteW", 32'(RegWriteW), 32'd0);
    check("rstw_after_StallM", 32'(StallM), 32'd0);
    rv_lo = 1; rv_hi = 1;
    issue(mk(32'h0000_0044, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01));
    idle(10);

    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
